// File: rtl/draw_to_grid.sv
// Rebuilds the 3x3 board from the pixel writes heading to the VGA adapter and
// publishes per-cell codes plus an error flag once per frame.
module draw_to_grid #(
    parameter logic [7:0]  X0      = 8'd10,
    parameter logic [6:0]  Y0      = 7'd10,
    parameter int unsigned PITCH   = 30,
    parameter int unsigned CELL_W  = 27,
    parameter logic [2:0]  EMPTY_C = 3'b111,
    parameter logic [2:0]  X_C     = 3'b100,
    parameter logic [2:0]  O_C     = 3'b001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic [17:0] grid_out,
    output logic        grid_valid,
    output logic        error,
    output logic        busy
);

    localparam logic [9:0] FullCount = 10'(CELL_W * CELL_W);
    localparam logic [9:0] MaxCount  = 10'd1023;

    typedef enum logic [2:0] {StIdle, StCapture, StDrain1, StDrain2, StPublish} state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   load_out;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM next state; frame_start restarts capture from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (frame_start) state_d = StCapture;
            StCapture: if (frame_end) state_d = StDrain1;
            StDrain1:  state_d = StDrain2;
            StDrain2:  state_d = StPublish;
            StPublish: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (frame_start) state_d = StCapture;
    end

    // FSM outputs; result registers load on the last drain cycle so they show in PUBLISH
    always_comb begin
        busy     = (state_q != StIdle);
        accept   = (state_q == StCapture) && plot && !frame_start;
        load_out = (state_q == StDrain2) && !frame_start;
    end

    // Stage 1: locate the pixel by range compares against the cell squares
    logic [1:0] row_idx, col_idx;
    logic       row_hit, col_hit;
    logic [3:0] cell_idx;

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        row_hit = 1'b0;
        col_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (32'(y) >= 32'(Y0) + 32'(i) * PITCH &&
                32'(y) <  32'(Y0) + 32'(i) * PITCH + CELL_W) begin
                row_hit = 1'b1;
                row_idx = 2'(i);
            end
            if (32'(x) >= 32'(X0) + 32'(i) * PITCH &&
                32'(x) <  32'(X0) + 32'(i) * PITCH + CELL_W) begin
                col_hit = 1'b1;
                col_idx = 2'(i);
            end
        end
        cell_idx = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx};
    end

    logic       s1_valid_q, s1_inside_q;
    logic [3:0] s1_cell_q;
    logic [2:0] s1_colour_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s1_inside_q <= 1'b0;
            s1_cell_q   <= '0;
            s1_colour_q <= '0;
        end else begin
            s1_valid_q  <= accept;
            s1_inside_q <= row_hit && col_hit;
            s1_cell_q   <= cell_idx;
            s1_colour_q <= colour;
        end
    end

    // Stage 2: per-cell count, first-pixel code and consistency flag
    logic [1:0] s1_code;
    logic       s1_legal;

    always_comb begin
        s1_code  = 2'd3;
        s1_legal = 1'b1;
        if      (s1_colour_q == EMPTY_C) s1_code = 2'd0;
        else if (s1_colour_q == X_C)     s1_code = 2'd1;
        else if (s1_colour_q == O_C)     s1_code = 2'd2;
        else                             s1_legal = 1'b0;
    end

    logic [9:0] cnt_q  [9];
    logic [1:0] code_q [9];
    logic [8:0] bad_q;

    always_ff @(posedge clk) begin
        if (!resetn || frame_start) begin
            for (int c = 0; c < 9; c++) begin
                cnt_q[c]  <= '0;
                code_q[c] <= '0;
            end
            bad_q <= '0;
        end else if (s1_valid_q && s1_inside_q) begin
            for (int c = 0; c < 9; c++) begin
                if (4'(c) == s1_cell_q) begin
                    if (cnt_q[c] != MaxCount) cnt_q[c] <= cnt_q[c] + 10'd1;
                    if (cnt_q[c] == '0) begin
                        code_q[c] <= s1_code;
                        if (!s1_legal) bad_q[c] <= 1'b1;
                    end else if (!s1_legal || s1_code != code_q[c]) begin
                        bad_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Publish: a cell is trusted only with exactly one full square of consistent pixels
    logic [8:0]  cell_ok;
    logic [17:0] grid_d;
    logic        error_d;

    always_comb begin
        grid_d  = '0;
        error_d = 1'b0;
        for (int c = 0; c < 9; c++) begin
            cell_ok[c]       = !bad_q[c] && (cnt_q[c] == FullCount);
            grid_d[2*c +: 2] = cell_ok[c] ? code_q[c] : 2'd3;
            error_d          = error_d | !cell_ok[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grid_out   <= '0;
            grid_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            grid_valid <= load_out;
            if (load_out) begin
                grid_out <= grid_d;
                error    <= error_d;
            end
        end
    end

endmodule

// File: tb/tb_draw_to_grid.sv
// Directed bench for draw_to_grid: draws whole boards pixel by pixel and checks
// the published grid, error flag and handshake timing.
module tb_draw_to_grid;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_start, frame_end, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic [17:0] grid_out;
    logic        grid_valid, error, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    draw_to_grid dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .grid_out    (grid_out),
        .grid_valid  (grid_valid),
        .error       (error),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] code2col(input logic [1:0] code);
        case (code)
            2'd0:    return 3'b111;
            2'd1:    return 3'b100;
            2'd2:    return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic pix(input int px, input int py, input logic [2:0] c);
        x      = 8'(px);
        y      = 7'(py);
        colour = c;
        plot   = 1'b1;
        step();
        plot   = 1'b0;
    endtask

    // mode: 0 full, 1 omit last pixel, 2 last pixel twice, 3 last pixel in alt colour
    task automatic draw_cell(input int r, input int c, input logic [2:0] col, input int mode,
                             input logic [2:0] alt);
        for (int yy = 0; yy < 27; yy++) begin
            for (int xx = 0; xx < 27; xx++) begin
                if (yy == 26 && xx == 26) begin
                    if (mode != 1) pix(10 + c*30 + xx, 10 + r*30 + yy, (mode == 3) ? alt : col);
                    if (mode == 2) pix(10 + c*30 + xx, 10 + r*30 + yy, col);
                end else begin
                    pix(10 + c*30 + xx, 10 + r*30 + yy, col);
                end
            end
        end
    endtask

    // Gridline and margin pixels must be ignored
    task automatic draw_lines();
        for (int k = 0; k < 30; k++) begin
            pix(37, 10 + k, 3'b000);
            pix(10 + k, 67, 3'b000);
            pix(98, 40 + k, 3'b000);
        end
        pix(0, 0, 3'b000);
        pix(200, 120, 3'b100);
    endtask

    task automatic draw_board(input logic [17:0] codes, input int sp, input int mode,
                              input logic [2:0] alt);
        draw_lines();
        for (int k = 0; k < 9; k++)
            draw_cell(k / 3, k % 3, code2col(codes[2*k +: 2]), (k == sp) ? mode : 0, alt);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic end_and_check(input string tag, input logic [17:0] eg, input logic ee);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_gv1"}, 32'(grid_valid), 32'd0);
        step();
        chk({tag, "_gv2"}, 32'(grid_valid), 32'd0);
        step();
        chk({tag, "_gv3"}, 32'(grid_valid), 32'd1);
        chk({tag, "_grid"}, 32'(grid_out), 32'(eg));
        chk({tag, "_err"}, 32'(error), 32'(ee));
        chk({tag, "_busy3"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_gv4"}, 32'(grid_valid), 32'd0);
        chk({tag, "_busy4"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(grid_out), 32'(eg));
        chk({tag, "_errhold"}, 32'(error), 32'(ee));
    endtask

    initial begin
        resetn      = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        plot        = 1'b0;
        x           = '0;
        y           = '0;
        colour      = '0;
        step();
        step();
        chk("rst_grid", 32'(grid_out), 32'd0);
        chk("rst_gv", 32'(grid_valid), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        step();

        // All-empty board
        start_frame();
        chk("start_busy", 32'(busy), 32'd1);
        draw_board(18'h00000, -1, 0, 3'b000);
        end_and_check("empty", 18'h00000, 1'b0);

        // X at cell 0, O at cell 4, X at cell 8: bits [1:0]=1, [9:8]=2, [17:16]=1
        start_frame();
        draw_board(18'h10201, -1, 0, 3'b000);
        end_and_check("xox", 18'h10201, 1'b0);

        // Same board with one O pixel in empty cell 2 -> cell 2 code 3
        start_frame();
        draw_board(18'h10201, 2, 3, 3'b001);
        end_and_check("mixed", 18'h10231, 1'b1);

        // Cell 7 short by one pixel, then overdrawn by one pixel
        start_frame();
        draw_board(18'h00000, 7, 1, 3'b000);
        end_and_check("short", 18'h0C000, 1'b1);
        start_frame();
        draw_board(18'h00000, 7, 2, 3'b000);
        end_and_check("over", 18'h0C000, 1'b1);

        // Reset mid-capture: frame_end afterwards must not publish
        start_frame();
        draw_cell(0, 0, 3'b100, 0, 3'b000);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grid", 32'(grid_out), 32'd0);
        chk("midrst_err", 32'(error), 32'd0);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("midrst_nopub", 32'(grid_valid), 32'd0);
            chk("midrst_idle", 32'(busy), 32'd0);
            step();
        end
        chk("midrst_grid2", 32'(grid_out), 32'd0);

        // Restart mid-capture: only the second frame's content is published
        start_frame();
        draw_cell(0, 0, 3'b100, 0, 3'b000);
        draw_cell(0, 1, 3'b100, 0, 3'b000);
        start_frame();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_nopub", 32'(grid_valid), 32'd0);
        draw_board(18'h00008, -1, 0, 3'b000);
        end_and_check("restart", 18'h00008, 1'b0);

        // frame_start together with frame_end: stays in capture, no publish
        start_frame();
        draw_cell(1, 1, 3'b001, 0, 3'b000);
        frame_start = 1'b1;
        frame_end   = 1'b1;
        step();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("both_busy", 32'(busy), 32'd1);
            chk("both_nopub", 32'(grid_valid), 32'd0);
            step();
        end
        chk("both_grid_held", 32'(grid_out), 32'(18'h00008));
        // Cell state was cleared, so every cell now has count 0
        end_and_check("both_end", 18'h3FFFF, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
